ptw_mem_arbiter: RTL and testbench

PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

---
 rtl/ptw_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_ptw_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_mem_arbiter.sv
// Page-table-walk read arbiter: merges IFU and LSU MMU walk reads onto one downstream port,
// one read in flight at a time. Define PTW_ARB_LS_PRIO_EN for a fixed LSU-wins-ties policy.
module ptw_mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_rvalid_o,
  input  logic          ls_req_i,
  input  logic [AW-1:0] ls_addr_i,
  output logic [DW-1:0] ls_rdata_o,
  output logic          ls_rvalid_o,
  output logic          mem_req_valid_o,
  input  logic          mem_req_ready_i,
  output logic [AW-1:0] mem_req_addr_o,
  input  logic          mem_resp_valid_i,
  input  logic [DW-1:0] mem_resp_data_i,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_DROP = 3'd4
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          flush_pend_q, flush_pend_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;
`ifndef PTW_ARB_LS_PRIO_EN
  owner_e        last_q, last_d;
`endif

  logic          grant_ls;
  logic [AW-1:0] sel_addr;
  logic          pulse;

  // A lone requester always wins; only a tie consults the policy.
`ifdef PTW_ARB_LS_PRIO_EN
  assign grant_ls = ls_req_i;
`else
  assign grant_ls = ls_req_i && (!if_req_i || (last_q == OWN_IF));
`endif

  assign sel_addr = grant_ls ? ls_addr_i : if_addr_i;

  // A flush arriving during RESP kills the pulse combinationally.
  assign pulse = (state_q == S_RESP) && !flush_i;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    resp_data_d  = resp_data_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
`ifndef PTW_ARB_LS_PRIO_EN
    last_d       = last_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (if_req_i || ls_req_i) begin
          owner_d = grant_ls ? OWN_LS : OWN_IF;
          addr_d  = sel_addr & WORD_MASK;
`ifndef PTW_ARB_LS_PRIO_EN
          last_d  = grant_ls ? OWN_LS : OWN_IF;
`endif
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_req_ready_i) begin
          state_d = (flush_pend_q || flush_i) ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = mem_resp_valid_i ? S_IDLE : S_DROP;
        end else if (mem_resp_valid_i) begin
          resp_data_d = mem_resp_data_i;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (pulse) begin
          if (owner_q == OWN_IF) if_rdata_d = resp_data_q;
          else                   ls_rdata_d = resp_data_q;
        end
      end
      S_DROP: begin
        if (mem_resp_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Any return to IDLE closes out whatever flush was outstanding.
    if (state_d == S_IDLE) flush_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      resp_data_q  <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
`ifndef PTW_ARB_LS_PRIO_EN
      last_q       <= OWN_IF;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      resp_data_q  <= resp_data_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
`ifndef PTW_ARB_LS_PRIO_EN
      last_q       <= last_d;
`endif
    end
  end

  assign if_rvalid_o     = pulse && (owner_q == OWN_IF);
  assign ls_rvalid_o     = pulse && (owner_q == OWN_LS);
  assign if_rdata_o      = if_rvalid_o ? resp_data_q : if_rdata_q;
  assign ls_rdata_o      = ls_rvalid_o ? resp_data_q : ls_rdata_q;
  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = addr_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed self-checking bench for ptw_mem_arbiter; expectations follow PTW_ARB_LS_PRIO_EN if defined.
module tb_ptw_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_rvalid_o;
  logic        ls_req_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_rdata_o;
  logic        ls_rvalid_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_data_i;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  ptw_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .if_req_i         (if_req_i),
    .if_addr_i        (if_addr_i),
    .if_rdata_o       (if_rdata_o),
    .if_rvalid_o      (if_rvalid_o),
    .ls_req_i         (ls_req_i),
    .ls_addr_i        (ls_addr_i),
    .ls_rdata_o       (ls_rdata_o),
    .ls_rvalid_o      (ls_rvalid_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] last_if_data;
  logic [31:0] last_ls_data;
  logic [31:0] data_k;
  logic        exp_ls;
  logic        found;

  initial begin
    rst_n = 1'b1;
    flush_i = 1'b0;
    if_req_i = 1'b0;
    if_addr_i = '0;
    ls_req_i = 1'b0;
    ls_addr_i = '0;
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_valid", mem_req_valid_o, 1'b0);
    check("rst_addr", mem_req_addr_o, 32'h0);
    check("rst_if_rvalid", if_rvalid_o, 1'b0);
    check("rst_ls_rvalid", ls_rvalid_o, 1'b0);
    check("rst_if_rdata", if_rdata_o, 32'h0);
    check("rst_ls_rdata", ls_rdata_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // IFU-only read, response two cycles after the handshake.
    if_req_i = 1'b1; if_addr_i = 32'h8000_1006; mem_req_ready_i = 1'b1;
    @(negedge clk);
    check("t1_idle_valid", mem_req_valid_o, 1'b0);
    check("t1_idle_busy", busy_o, 1'b0);
    tick();
    @(negedge clk);
    check("t1_req_valid", mem_req_valid_o, 1'b1);
    check("t1_req_addr", mem_req_addr_o, 32'h8000_1004);
    check("t1_req_busy", busy_o, 1'b1);
    tick();
    @(negedge clk);
    check("t1_wait_valid", mem_req_valid_o, 1'b0);
    tick();
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h2000_00CF;
    @(negedge clk);
    check("t1_wait_rvalid", if_rvalid_o, 1'b0);
    tick();
    mem_resp_valid_i = 1'b0;
    @(negedge clk);
    check("t1_if_rvalid", if_rvalid_o, 1'b1);
    check("t1_if_rdata", if_rdata_o, 32'h2000_00CF);
    check("t1_ls_rvalid", ls_rvalid_o, 1'b0);
    tick();
    if_req_i = 1'b0;
    @(negedge clk);
    check("t1_after_rvalid", if_rvalid_o, 1'b0);
    check("t1_rdata_hold", if_rdata_o, 32'h2000_00CF);
    check("t1_after_busy", busy_o, 1'b0);
    tick();
    last_if_data = 32'h2000_00CF;
    last_ls_data = 32'h0;

    // Both requesting continuously; LSU wins the first tie after an IFU grant.
    if_req_i = 1'b1; if_addr_i = 32'h2000_0001;
    ls_req_i = 1'b1; ls_addr_i = 32'h1000_0003;
    mem_resp_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_k = 32'hA5A5_0000 + 32'(k);
      mem_resp_data_i = data_k;
`ifdef PTW_ARB_LS_PRIO_EN
      exp_ls = 1'b1;
`else
      exp_ls = (k % 2 == 0);
`endif
      found = 1'b0;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (if_rvalid_o || ls_rvalid_o) begin
          found = 1'b1;
          break;
        end
      end
      check("t2_found", found, 1'b1);
      check("t2_ls_rvalid", ls_rvalid_o, exp_ls);
      check("t2_if_rvalid", if_rvalid_o, !exp_ls);
      if (exp_ls) begin
        check("t2_ls_rdata", ls_rdata_o, data_k);
        check("t2_if_hold", if_rdata_o, last_if_data);
        last_ls_data = data_k;
      end else begin
        check("t2_if_rdata", if_rdata_o, data_k);
        check("t2_ls_hold", ls_rdata_o, last_ls_data);
        last_if_data = data_k;
      end
      tick();
    end
    if_req_i = 1'b0; ls_req_i = 1'b0; mem_resp_valid_i = 1'b0;
    @(negedge clk);
    check("t2_idle_busy", busy_o, 1'b0);
    tick();

    // Flush in WAIT; response three cycles later is dropped.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100; mem_req_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("t3_req_addr", mem_req_addr_o, 32'h0000_0100);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    check("t3_wait_busy", busy_o, 1'b1);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check("t3_drop_busy", busy_o, 1'b1);
    check("t3_drop_rvalid", if_rvalid_o, 1'b0);
    tick();
    tick();
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h1234_5678;
    @(negedge clk);
    check("t3_resp_rvalid", if_rvalid_o, 1'b0);
    check("t3_resp_busy", busy_o, 1'b1);
    tick();
    mem_resp_valid_i = 1'b0; if_addr_i = 32'h0000_0208;
    @(negedge clk);
    check("t3_busy_fall", busy_o, 1'b0);
    check("t3_no_rvalid", if_rvalid_o, 1'b0);
    check("t3_rdata_hold", if_rdata_o, last_if_data);
    tick();
    @(negedge clk);
    check("t3_retry_valid", mem_req_valid_o, 1'b1);
    check("t3_retry_addr", mem_req_addr_o, 32'h0000_0208);
    tick();
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h0BAD_F00D;
    tick();
    mem_resp_valid_i = 1'b0;
    @(negedge clk);
    check("t3_retry_rvalid", if_rvalid_o, 1'b1);
    check("t3_retry_rdata", if_rdata_o, 32'h0BAD_F00D);
    last_if_data = 32'h0BAD_F00D;
    tick();
    if_req_i = 1'b0;
    tick();

    // Ready held low five cycles, flush in the second; request must stay stable.
    ls_req_i = 1'b1; ls_addr_i = 32'h4000_0ABF; mem_req_ready_i = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      flush_i = (i == 2);
      @(negedge clk);
      check("t4_stall_valid", mem_req_valid_o, 1'b1);
      check("t4_stall_addr", mem_req_addr_o, 32'h4000_0ABC);
      tick();
    end
    flush_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk);
    check("t4_hs_valid", mem_req_valid_o, 1'b1);
    tick();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_drop_busy", busy_o, 1'b1);
    check("t4_drop_valid", mem_req_valid_o, 1'b0);
    check("t4_drop_rvalid", ls_rvalid_o, 1'b0);
    tick();
    mem_resp_valid_i = 1'b0; ls_req_i = 1'b0;
    @(negedge clk);
    check("t4_idle_busy", busy_o, 1'b0);
    check("t4_idle_rvalid", ls_rvalid_o, 1'b0);
    check("t4_rdata_hold", ls_rdata_o, last_ls_data);
    tick();

    // Asynchronous reset during WAIT, then a stale response.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0300; mem_req_ready_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("t5_wait_busy", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_busy", busy_o, 1'b0);
    check("t5_async_valid", mem_req_valid_o, 1'b0);
    check("t5_async_addr", mem_req_addr_o, 32'h0);
    check("t5_async_if_rdata", if_rdata_o, 32'h0);
    check("t5_async_ls_rdata", ls_rdata_o, 32'h0);
    if_req_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h0000_0055;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_stale_if_rvalid", if_rvalid_o, 1'b0);
      check("t5_stale_ls_rvalid", ls_rvalid_o, 1'b0);
      check("t5_stale_busy", busy_o, 1'b0);
      tick();
    end
    mem_resp_valid_i = 1'b0;

    // Pointer restored by reset: LSU takes the first tie.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    ls_req_i = 1'b1; ls_addr_i = 32'h0000_0020;
    tick();
    @(negedge clk);
    check("t5_tie_valid", mem_req_valid_o, 1'b1);
    check("t5_tie_addr", mem_req_addr_o, 32'h0000_0020);
    tick();
    if_req_i = 1'b0; ls_req_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
